// File: rtl/speed_decode.sv
// speed_decode
//   Measures the rising-edge-to-rising-edge period of an asynchronous speed
//   pulse train, rejects glitches shorter than MIN_PERIOD, flags boosted
//   rates (period < BOOST_THRESH) and declares a stall after TIMEOUT cycles
//   without an accepted rise.
//
//   Ports
//     clk           system clock, all state changes on its rising edge
//     rst_n         asynchronous active-low reset
//     speed_in      asynchronous speed pulse train
//     period_out    last accepted period in cycles (0 when stalled)
//     period_strobe one-cycle pulse when period_out updates
//     period_valid  period_out holds a live measurement
//     boost         live period is below BOOST_THRESH
//     stalled       no pulse train present (state IDLE)
//
//   Legal parameters: MIN_PERIOD >= 2, MIN_PERIOD < TIMEOUT < 2**PERIOD_W.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no pulse train; cnt held at 0; first rise only arms
//   ARMED | one rise seen, counting towards the first full period
//   RUN   | at least one period accepted; period_out is live

module speed_decode #(
    parameter int PERIOD_W     = 16,
    parameter int TIMEOUT      = 50000,
    parameter int MIN_PERIOD   = 4,
    parameter int BOOST_THRESH = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                speed_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_strobe,
    output logic                period_valid,
    output logic                boost,
    output logic                stalled
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] BOOST_P = PERIOD_W'(BOOST_THRESH);
    localparam logic [PERIOD_W-1:0] TO_LAST = PERIOD_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                r_primed;
    logic                r_seen_low;
    logic [PERIOD_W-1:0] r_period;
    logic                r_strobe;
    logic                r_valid;
    logic                r_boost;

    logic                w_rise;
    logic [PERIOD_W-1:0] w_cnt_inc;
    logic                w_accept;
    logic                w_timeout;

    // The synchronizer resets to 0, so a line already high at release would
    // look like a rise. r_seen_low only opens the detector once a genuine
    // low sample (taken after reset, hence r_primed) has been observed.
    assign w_rise    = r_sync2 & ~r_sync3 & r_seen_low;
    // cnt never exceeds TIMEOUT-1 < 2**PERIOD_W, so the increment cannot wrap.
    assign w_cnt_inc = r_cnt + PERIOD_W'(1);
    assign w_accept  = w_rise && (w_cnt_inc >= MIN_P);
    assign w_timeout = (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_primed   <= 1'b0;
            r_seen_low <= 1'b0;
            r_period   <= '0;
            r_strobe   <= 1'b0;
            r_valid    <= 1'b0;
            r_boost    <= 1'b0;
        end else begin
            r_sync1  <= speed_in;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_primed <= 1'b1;
            if (r_primed && !r_sync1) begin
                r_seen_low <= 1'b1;
            end
            r_strobe <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= ARMED;
                    end
                end
                ARMED, RUN: begin
                    // An accepted rise wins over a timeout in the same cycle.
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_cnt    <= '0;
                        r_period <= w_cnt_inc;
                        r_strobe <= 1'b1;
                        r_valid  <= 1'b1;
                        r_boost  <= (w_cnt_inc < BOOST_P);
                    end else if (w_timeout) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_period <= '0;
                        r_valid  <= 1'b0;
                        r_boost  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign period_out    = r_period;
    assign period_strobe = r_strobe;
    assign period_valid  = r_valid;
    assign boost         = r_boost;
    assign stalled       = (r_state == IDLE);

endmodule

// File: tb/tb_speed_decode.sv
module tb_speed_decode;

    localparam int PW = 16;

    logic          clk;
    logic          rst_n;
    logic          speed_in;
    logic [PW-1:0] period_out;
    logic          period_strobe;
    logic          period_valid;
    logic          boost;
    logic          stalled;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;

    speed_decode #(
        .PERIOD_W    (PW),
        .TIMEOUT     (64),
        .MIN_PERIOD  (4),
        .BOOST_THRESH(20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .speed_in     (speed_in),
        .period_out   (period_out),
        .period_strobe(period_strobe),
        .period_valid (period_valid),
        .boost        (boost),
        .stalled      (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_strobe) strobe_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [PW-1:0] e_per,
                              input logic e_stb, input logic e_val,
                              input logic e_bst, input logic e_stl);
        n_checks++;
        if (period_out !== e_per) begin
            n_fail++;
            $display("FAIL %s period_out: got %0d expected %0d", name, period_out, e_per);
        end
        n_checks++;
        if (period_strobe !== e_stb) begin
            n_fail++;
            $display("FAIL %s period_strobe: got %b expected %b", name, period_strobe, e_stb);
        end
        n_checks++;
        if (period_valid !== e_val) begin
            n_fail++;
            $display("FAIL %s period_valid: got %b expected %b", name, period_valid, e_val);
        end
        n_checks++;
        if (boost !== e_bst) begin
            n_fail++;
            $display("FAIL %s boost: got %b expected %b", name, boost, e_bst);
        end
        n_checks++;
        if (stalled !== e_stl) begin
            n_fail++;
            $display("FAIL %s stalled: got %b expected %b", name, stalled, e_stl);
        end
    endtask

    // One pulse: high for hi cycles, low for the rest of total cycles.
    // Outputs are checked right after the update edge (3 edges after the
    // rise is driven) and the strobe must be gone one cycle later.
    task automatic do_rise(input string name, input int hi, input int total,
                           input logic [PW-1:0] e_per, input logic e_stb,
                           input logic e_val, input logic e_bst, input logic e_stl);
        speed_in = 1'b1;
        cyc(3);
        check_outs(name, e_per, e_stb, e_val, e_bst, e_stl);
        cyc(1);
        n_checks++;
        if (period_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s strobe_width: got %b expected 0", name, period_strobe);
        end
        cyc(hi - 4);
        speed_in = 1'b0;
        cyc(total - hi);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        speed_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            speed_in = ~speed_in;
            cyc(1);
        end
        check_outs("reset_hold", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        speed_in = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        check_outs("reset_release", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_rise("first_rise_arms", 15, 30, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_plain;
        do_rise("plain_1", 15, 30, 16'd30, 1'b1, 1'b1, 1'b0, 1'b0);
        do_rise("plain_2", 15, 30, 16'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_boost;
        strobe_cnt = 0;
        do_rise("boost_last30", 5, 10, 16'd30, 1'b1, 1'b1, 1'b0, 1'b0);
        do_rise("boost_first10", 5, 10, 16'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        do_rise("boost_second10", 5, 10, 16'd10, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (strobe_cnt !== 3) begin
            n_fail++;
            $display("FAIL boost_strobe_count: got %0d expected 3", strobe_cnt);
        end
    endtask

    task automatic test_glitch;
        strobe_cnt = 0;
        speed_in = 1'b1;
        cyc(1);
        speed_in = 1'b0;
        cyc(1);
        speed_in = 1'b1;
        cyc(1);
        speed_in = 1'b0;
        cyc(27);
        n_checks++;
        if (strobe_cnt !== 1) begin
            n_fail++;
            $display("FAIL glitch_strobe_count: got %0d expected 1", strobe_cnt);
        end
        check_outs("glitch_hold", 16'd10, 1'b0, 1'b1, 1'b1, 1'b0);
        do_rise("glitch_next", 15, 30, 16'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        cyc(36);
        check_outs("timeout_before", 16'd30, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1);
        check_outs("timeout_at", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_rise("timeout_rearm", 15, 64, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous;
        do_rise("simul_64", 15, 30, 16'd64, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        cyc(5);
        speed_in = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        check_outs("mid_reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(3);
        rst_n = 1'b1;
        strobe_cnt = 0;
        cyc(8);
        check_outs("high_at_release", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (strobe_cnt !== 0) begin
            n_fail++;
            $display("FAIL high_at_release_strobes: got %0d expected 0", strobe_cnt);
        end
        speed_in = 1'b0;
        cyc(5);
        check_outs("low_after_release", 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_rise("post_reset_arm", 15, 30, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_rise("post_reset_run", 15, 30, 16'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        speed_in = 1'b0;
        test_reset;
        test_plain;
        test_boost;
        test_glitch;
        test_timeout;
        test_simultaneous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
